// File: rtl/mem_request_sequencer_pkg.sv
// Shared types for the memory request sequencer: RAM handshake status,
// sequencer states and the datapath word width.
package mem_request_sequencer_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        DATA   = 3'd2,
        HALTED = 3'd3,
        FAULT  = 3'd4
    } seqstate_t;

endpackage

// File: rtl/mem_request_sequencer_if.sv
// Bundles the sequencer's control-unit and RAM-side signals; 'seq' is the
// sequencer's view, 'tb' the view of whatever drives and observes it.
interface mem_request_sequencer_if;
    import mem_request_sequencer_pkg::*;

    logic      cu_dREN;
    logic      cu_dWEN;
    logic      cu_halt;
    word_t     imemaddr;
    word_t     dmemaddr;
    word_t     dmemstore;
    ramstate_t ramstate;
    word_t     ramload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     imemload;
    word_t     dmemload;
    logic      ihit;
    logic      dhit;
    logic      pc_en;
    logic      halt;
    logic      fault;

    modport seq (
        input  cu_dREN, cu_dWEN, cu_halt, imemaddr, dmemaddr, dmemstore,
               ramstate, ramload,
        output ramREN, ramWEN, ramaddr, ramstore, imemload, dmemload,
               ihit, dhit, pc_en, halt, fault
    );

    modport tb (
        output cu_dREN, cu_dWEN, cu_halt, imemaddr, dmemaddr, dmemstore,
               ramstate, ramload,
        input  ramREN, ramWEN, ramaddr, ramstore, imemload, dmemload,
               ihit, dhit, pc_en, halt, fault
    );

endinterface

// File: rtl/req_watchdog.sv
// Saturating wait-cycle counter for one outstanding RAM request; flags
// expiry once TIMEOUT non-completing cycles have been counted.
module req_watchdog #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_request_sequencer.sv
// Steps each instruction through fetch, decode and an optional data access
// on the single shared RAM port, granting PC advance when the work is done.
module mem_request_sequencer
    import mem_request_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      cu_dREN,
    input  logic      cu_dWEN,
    input  logic      cu_halt,
    input  word_t     imemaddr,
    input  word_t     dmemaddr,
    input  word_t     dmemstore,
    input  ramstate_t ramstate,
    input  word_t     ramload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    output word_t     imemload,
    output word_t     dmemload,
    output logic      ihit,
    output logic      dhit,
    output logic      pc_en,
    output logic      halt,
    output logic      fault
);

    seqstate_t state;
    seqstate_t stateNext;
    logic      goFault;
    logic      wdClear;
    logic      wdEnable;
    logic      wdExpired;

    // Every fresh FETCH/DATA request restarts its own wait budget.
    assign wdClear  = (stateNext != state) && ((stateNext == FETCH) || (stateNext == DATA));
    assign wdEnable = ((state == FETCH) || (state == DATA)) && (ramstate != ACCESS);

    req_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) watchdog (
        .clock   (CLK),
        .reset   (RST),
        .clear   (wdClear),
        .enable  (wdEnable),
        .expired (wdExpired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= FETCH;
            imemload <= '0;
            dmemload <= '0;
        end else begin
            state <= stateNext;
            if (ihit) begin
                imemload <= ramload;
            end
            if (dhit && cu_dREN) begin
                dmemload <= ramload;
            end
        end
    end

    // ACCESS is tested first so a completing request beats a same-cycle timeout.
    always_comb begin
        stateNext = state;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        pc_en     = 1'b0;
        goFault   = 1'b0;
        case (state)
            FETCH: begin
                ramREN  = 1'b1;
                ramaddr = imemaddr;
                if (ramstate == ACCESS) begin
                    ihit      = 1'b1;
                    stateNext = DECODE;
                end else if ((ramstate == ERROR) || wdExpired) begin
                    goFault   = 1'b1;
                    stateNext = FAULT;
                end
            end
            DECODE: begin
                if (cu_halt) begin
                    stateNext = HALTED;
                end else if (cu_dREN && cu_dWEN) begin
                    goFault   = 1'b1;
                    stateNext = FAULT;
                end else if (cu_dREN || cu_dWEN) begin
                    stateNext = DATA;
                end else begin
                    pc_en     = 1'b1;
                    stateNext = FETCH;
                end
            end
            DATA: begin
                ramREN   = cu_dREN;
                ramWEN   = cu_dWEN;
                ramaddr  = dmemaddr;
                ramstore = dmemstore;
                if (ramstate == ACCESS) begin
                    dhit      = 1'b1;
                    pc_en     = 1'b1;
                    stateNext = FETCH;
                end else if ((ramstate == ERROR) || wdExpired) begin
                    goFault   = 1'b1;
                    stateNext = FAULT;
                end
            end
            HALTED: stateNext = HALTED;
            FAULT:  stateNext = FAULT;
            default: stateNext = FETCH;
        endcase
        if (RST) begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = '0;
            ramstore = '0;
            ihit     = 1'b0;
            dhit     = 1'b0;
            pc_en    = 1'b0;
            goFault  = 1'b0;
        end
    end

    // fault rises in the detecting cycle and then stays up from the FAULT state.
    assign halt  = (state == HALTED);
    assign fault = (state == FAULT) || goFault;

endmodule
